// File: rtl/register_file_c.sv
// 16-entry register file with two bypassed combinational read ports and a
// pending-write scoreboard used by decode to stall on RAW hazards.
module register_file_c #(
    parameter int unsigned WIDTH   = 32,
    parameter bit          ZERO_R0 = 1'b1
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic [3:0]       C_Addr,
    input  logic             RF_LE,
    input  logic [WIDTH-1:0] PW,
    input  logic [3:0]       A_Addr,
    input  logic [3:0]       B_Addr,
    output logic [WIDTH-1:0] PA,
    output logic [WIDTH-1:0] PB,
    input  logic             Issue,
    input  logic [3:0]       Issue_Addr,
    output logic             Busy_A,
    output logic             Busy_B
);

    logic [WIDTH-1:0] regs_q [16];
    logic [15:0]      pending_q;
    logic [15:0]      pending_d;
    logic             wr_en;
    logic             issue_en;

    assign wr_en    = Clr && RF_LE && !(ZERO_R0 && (C_Addr == 4'd0));
    assign issue_en = Clr && Issue && !(ZERO_R0 && (Issue_Addr == 4'd0));

    // Clear is applied before set so a same-register issue/writeback keeps the bit.
    always_comb begin
        pending_d = pending_q;
        if (Clr && RF_LE) begin
            pending_d[C_Addr] = 1'b0;
        end
        if (issue_en) begin
            pending_d[Issue_Addr] = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            for (int unsigned i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
            pending_q <= '0;
        end else begin
            if (wr_en) begin
                regs_q[C_Addr] <= PW;
            end
            pending_q <= pending_d;
        end
    end

    always_comb begin
        PA = '0;
        if (Clr && !(ZERO_R0 && (A_Addr == 4'd0))) begin
            PA = (wr_en && (C_Addr == A_Addr)) ? PW : regs_q[A_Addr];
        end
    end

    always_comb begin
        PB = '0;
        if (Clr && !(ZERO_R0 && (B_Addr == 4'd0))) begin
            PB = (wr_en && (C_Addr == B_Addr)) ? PW : regs_q[B_Addr];
        end
    end

    // A writeback in progress resolves the hazard through the bypass path.
    assign Busy_A = Clr && pending_q[A_Addr] && !(RF_LE && (C_Addr == A_Addr))
                    && !(ZERO_R0 && (A_Addr == 4'd0));
    assign Busy_B = Clr && pending_q[B_Addr] && !(RF_LE && (C_Addr == B_Addr))
                    && !(ZERO_R0 && (B_Addr == 4'd0));

endmodule

// File: tb/tb_register_file_c.sv
// Directed-vector bench for register_file_c: reset, write/bypass, R0/R15,
// scoreboard set/clear and collisions, asynchronous reset mid-flight.
module tb_register_file_c;

    logic        Clk = 1'b0;
    logic        Clr;
    logic [3:0]  C_Addr;
    logic        RF_LE;
    logic [31:0] PW;
    logic [3:0]  A_Addr;
    logic [3:0]  B_Addr;
    logic [31:0] PA;
    logic [31:0] PB;
    logic        Issue;
    logic [3:0]  Issue_Addr;
    logic        Busy_A;
    logic        Busy_B;

    int n_vec = 0;
    int n_err = 0;

    register_file_c #(.WIDTH(32), .ZERO_R0(1'b1)) dut (
        .Clk        (Clk),
        .Clr        (Clr),
        .C_Addr     (C_Addr),
        .RF_LE      (RF_LE),
        .PW         (PW),
        .A_Addr     (A_Addr),
        .B_Addr     (B_Addr),
        .PA         (PA),
        .PB         (PB),
        .Issue      (Issue),
        .Issue_Addr (Issue_Addr),
        .Busy_A     (Busy_A),
        .Busy_B     (Busy_B)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change 1 ns after it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Clr = 1'b0; RF_LE = 1'b1; C_Addr = 4'd5; PW = 32'hDEADBEEF;
        Issue = 1'b1; Issue_Addr = 4'd5; A_Addr = '0; B_Addr = '0;
        tick(); tick();
        for (int a = 0; a < 16; a++) begin
            A_Addr = 4'(a); B_Addr = 4'(a);
            #1;
            check("rst_PA", PA, 32'h0);
            check("rst_PB", PB, 32'h0);
            check("rst_BusyA", {31'd0, Busy_A}, 32'd0);
            check("rst_BusyB", {31'd0, Busy_B}, 32'd0);
        end
        Clr = 1'b1; RF_LE = 1'b0; Issue = 1'b0;
        tick();
        A_Addr = 4'd5; #1;
        check("post_rst_R5", PA, 32'h0);
        check("post_rst_busy5", {31'd0, Busy_A}, 32'd0);

        // write R3 with same-cycle bypass
        tick();
        RF_LE = 1'b1; C_Addr = 4'd3; PW = 32'h12345678; A_Addr = 4'd3; #1;
        check("bypass_R3", PA, 32'h12345678);
        tick();
        RF_LE = 1'b0; #1;
        check("stored_R3", PA, 32'h12345678);
        B_Addr = 4'd4; #1;
        check("unwritten_R4", PB, 32'h0);

        // R0 discard, R15 link register
        tick();
        RF_LE = 1'b1; C_Addr = 4'd0; PW = 32'hFFFFFFFF; A_Addr = 4'd0; #1;
        check("r0_write_cycle", PA, 32'h0);
        tick();
        RF_LE = 1'b0; #1;
        check("r0_after", PA, 32'h0);
        RF_LE = 1'b1; C_Addr = 4'd15; PW = 32'h00000040; B_Addr = 4'd15; #1;
        check("r15_bypass", PB, 32'h00000040);
        tick();
        RF_LE = 1'b0; #1;
        check("r15_stored", PB, 32'h00000040);

        // scoreboard set then clear by writeback
        Issue = 1'b1; Issue_Addr = 4'd7; A_Addr = 4'd7; B_Addr = 4'd7; #1;
        check("r7_not_yet_busy", {31'd0, Busy_A}, 32'd0);
        tick();
        Issue = 1'b0; #1;
        check("r7_busyA", {31'd0, Busy_A}, 32'd1);
        check("r7_busyB", {31'd0, Busy_B}, 32'd1);
        tick();
        check("r7_still_busy", {31'd0, Busy_A}, 32'd1);
        RF_LE = 1'b1; C_Addr = 4'd7; PW = 32'h000000A5; #1;
        check("r7_wb_busy", {31'd0, Busy_A}, 32'd0);
        check("r7_wb_PA", PA, 32'h000000A5);
        tick();
        RF_LE = 1'b0; #1;
        check("r7_cleared", {31'd0, Busy_A}, 32'd0);
        check("r7_value", PA, 32'h000000A5);

        // same-register issue and writeback: set wins
        Issue = 1'b1; Issue_Addr = 4'd9;
        tick();
        Issue = 1'b0; A_Addr = 4'd9; #1;
        check("r9_pending", {31'd0, Busy_A}, 32'd1);
        Issue = 1'b1; Issue_Addr = 4'd9; RF_LE = 1'b1; C_Addr = 4'd9; PW = 32'h99; #1;
        check("r9_collide_cycle", {31'd0, Busy_A}, 32'd0);
        tick();
        Issue = 1'b0; RF_LE = 1'b0; #1;
        check("r9_set_wins", {31'd0, Busy_A}, 32'd1);
        check("r9_value", PA, 32'h99);

        // different-register issue and writeback
        Issue = 1'b1; Issue_Addr = 4'd2; RF_LE = 1'b1; C_Addr = 4'd9; PW = 32'h77;
        tick();
        Issue = 1'b0; RF_LE = 1'b0; A_Addr = 4'd2; B_Addr = 4'd9; #1;
        check("r2_busy", {31'd0, Busy_A}, 32'd1);
        check("r9_free", {31'd0, Busy_B}, 32'd0);
        check("r9_new_value", PB, 32'h77);

        // issue to R0 is ignored
        Issue = 1'b1; Issue_Addr = 4'd0;
        tick();
        Issue = 1'b0; A_Addr = 4'd0; #1;
        check("r0_never_busy", {31'd0, Busy_A}, 32'd0);

        // asynchronous reset with R1 and R6 pending
        Issue = 1'b1; Issue_Addr = 4'd1; RF_LE = 1'b1; C_Addr = 4'd1; PW = 32'h11;
        tick();
        RF_LE = 1'b0; Issue_Addr = 4'd6;
        tick();
        Issue = 1'b0; A_Addr = 4'd1; B_Addr = 4'd6; #1;
        check("r1_busy", {31'd0, Busy_A}, 32'd1);
        check("r1_value", PA, 32'h11);
        check("r6_busy", {31'd0, Busy_B}, 32'd1);
        #1;
        Clr = 1'b0; #1;
        check("async_busyA", {31'd0, Busy_A}, 32'd0);
        check("async_PA", PA, 32'h0);
        check("async_busyB", {31'd0, Busy_B}, 32'd0);
        RF_LE = 1'b1; C_Addr = 4'd6; PW = 32'h66; #1;
        check("rst_no_bypass", PB, 32'h0);
        tick();
        RF_LE = 1'b0; Clr = 1'b1; #1;
        check("rel_busyA", {31'd0, Busy_A}, 32'd0);
        check("rel_busyB", {31'd0, Busy_B}, 32'd0);
        check("rel_R1", PA, 32'h0);
        check("rel_R6", PB, 32'h0);
        A_Addr = 4'd3; #1;
        check("rel_R3", PA, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
